// File: rtl/bp_pkg.sv
// Shared types and constants for the backplane packet arbiter.
// Bus strobes bpvl/bdvl are active-low; the *_ON constants name the asserted level.
package bp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } bp_state_e;

    localparam int NREQ_DEF      = 4;
    localparam int DW_DEF        = 32;
    localparam int MAX_WORDS_DEF = 64;
    localparam int STALL_MAX_DEF = 16;
    localparam int IDLE_GAP_DEF  = 2;

    localparam logic BPVL_ON = 1'b0;
    localparam logic BDVL_ON = 1'b0;

endpackage

// File: rtl/bp_rr_arb.sv
// Round-robin one-hot picker: search starts one past the last winner.
// The last winner only advances when the caller takes the grant.
module bp_rr_arb
    import bp_pkg::*;
#(
    parameter int NREQ = NREQ_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            take,
    output logic [NREQ-1:0] pick,
    output logic            valid
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0] last_idx;
    logic [IW-1:0] pick_idx;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int off);
        return IW'((int'(base) + off) % NREQ);
    endfunction

    always_comb begin
        valid    = 1'b0;
        pick_idx = last_idx;
        for (int k = 1; k <= NREQ; k++) begin
            if (!valid && req[rr_idx(last_idx, k)]) begin
                valid    = 1'b1;
                pick_idx = rr_idx(last_idx, k);
            end
        end
        pick           = '0;
        pick[pick_idx] = valid;
    end

    // Reset to the top index so requester 0 is the first winner.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_idx <= IW'(NREQ - 1);
        else if (take && valid)
            last_idx <= pick_idx;
    end

endmodule

// File: rtl/bp_arbiter.sv
// Backplane packet arbiter: grants one requester per packet and drives the
// registered bus with truncation, stall-abort and inter-packet gap handling.
//
//   state | meaning
//   IDLE  | bus idle, grant the round-robin winner when any req is set
//   XFER  | forward the granted requester's words until last/trunc/abort
//   GAP   | bus idle for IDLE_GAP cycles, no new grants
module bp_arbiter
    import bp_pkg::*;
#(
    parameter int NREQ      = NREQ_DEF,
    parameter int DW        = DW_DEF,
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter int STALL_MAX = STALL_MAX_DEF,
    parameter int IDLE_GAP  = IDLE_GAP_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    src_dv,
    input  logic [NREQ-1:0]    src_last,
    input  logic [NREQ*DW-1:0] src_data,
    output logic [NREQ-1:0]    gnt,
    output logic               bpvl,
    output logic               bdvl,
    output logic               bepvl,
    output logic [DW-1:0]      bdata,
    output logic               abort_err,
    output logic               trunc_err,
    output logic [15:0]        pkt_cnt
);

    localparam int SW = $clog2(STALL_MAX + 1);
    localparam int GW = (IDLE_GAP > 1) ? $clog2(IDLE_GAP) : 1;
    localparam logic [6:0]    WORD_LAST  = 7'(MAX_WORDS);
    localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);
    localparam logic [GW-1:0] GAP_LOAD   = GW'(IDLE_GAP - 1);

    bp_state_e       state, state_nx;
    logic [6:0]      word_cnt, word_num;
    logic [SW-1:0]   stall_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [NREQ-1:0] arb_pick;
    logic            arb_valid;
    logic            grant, acc, end_ok, trunc_hit, stall_hit, pkt_end;
    logic            g_dv, g_last;
    logic [DW-1:0]   g_data;
    logic            bpvl_nx, bdvl_nx, bepvl_nx, abort_nx, trunc_nx;
    logic [DW-1:0]   bdata_nx;

    bp_rr_arb #(.NREQ(NREQ)) u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .take  (grant),
        .pick  (arb_pick),
        .valid (arb_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        g_dv   = |(src_dv & gnt);
        g_last = |(src_last & gnt);
        g_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (gnt[i]) g_data = src_data[i*DW +: DW];

        word_num  = word_cnt + 7'd1;
        grant     = (state == IDLE) && arb_valid;
        acc       = (state == XFER) && g_dv;
        end_ok    = acc && (g_last || word_num == WORD_LAST);
        trunc_hit = acc && !g_last && word_num == WORD_LAST;
        stall_hit = (state == XFER) && !g_dv && stall_cnt == STALL_LAST;
        pkt_end   = end_ok || stall_hit;

        state_nx = state;
        case (state)
            IDLE:    if (grant)           state_nx = XFER;
            XFER:    if (pkt_end)         state_nx = GAP;
            GAP:     if (gap_cnt == '0)   state_nx = IDLE;
            default:                      state_nx = IDLE;
        endcase
    end

    // bpvl asserts with the grant so the idle gap seen on the bus equals IDLE_GAP.
    always_comb begin
        bpvl_nx  = ~BPVL_ON;
        bdvl_nx  = ~BDVL_ON;
        bepvl_nx = 1'b0;
        bdata_nx = bdata;
        abort_nx = 1'b0;
        trunc_nx = 1'b0;
        case (state)
            IDLE: if (grant) bpvl_nx = BPVL_ON;
            XFER: begin
                bpvl_nx = BPVL_ON;
                if (acc) begin
                    bdvl_nx  = BDVL_ON;
                    bdata_nx = g_data;
                    bepvl_nx = end_ok;
                    trunc_nx = trunc_hit;
                end else if (stall_hit) begin
                    bdvl_nx  = BDVL_ON;
                    bdata_nx = '0;
                    bepvl_nx = 1'b1;
                    abort_nx = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            bpvl      <= ~BPVL_ON;
            bdvl      <= ~BDVL_ON;
            bepvl     <= 1'b0;
            bdata     <= '0;
            abort_err <= 1'b0;
            trunc_err <= 1'b0;
            pkt_cnt   <= '0;
            word_cnt  <= '0;
            stall_cnt <= '0;
            gap_cnt   <= '0;
        end else begin
            bpvl      <= bpvl_nx;
            bdvl      <= bdvl_nx;
            bepvl     <= bepvl_nx;
            bdata     <= bdata_nx;
            abort_err <= abort_nx;
            trunc_err <= trunc_nx;
            if (grant) begin
                gnt       <= arb_pick;
                word_cnt  <= '0;
                stall_cnt <= '0;
            end else if (state == XFER) begin
                if (pkt_end) gnt <= '0;
                if (acc) begin
                    word_cnt  <= word_num;
                    stall_cnt <= '0;
                end else begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end
            if (pkt_end) begin
                pkt_cnt <= pkt_cnt + 16'd1;
                gap_cnt <= GAP_LOAD;
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

endmodule

// File: doc/bp_arbiter.md
BP_ARBITER -- requirements
Module: bp_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the backplane packet bus.
REQ-002 Parameter DW, default 32: backplane data width.
REQ-003 Parameter MAX_WORDS, default 64: maximum words per packet.
REQ-004 Parameter STALL_MAX, default 16: consecutive idle-data cycles tolerated inside a packet.
REQ-005 Parameter IDLE_GAP, default 2: minimum bus-idle cycles between packets.
REQ-006 clk  input  1  single clock; all logic on posedge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 req  input  NREQ  per-requester request; bit i asks for the bus.
REQ-009 src_dv  input  NREQ  per-requester word valid.
REQ-010 src_last  input  NREQ  per-requester last-word flag, qualified by src_dv.
REQ-011 src_data  input  NREQ*DW  per-requester data; slice i = bits [i*DW +: DW].
REQ-012 gnt  output  NREQ  one-hot grant; all-zero when no packet is in progress.
REQ-013 bpvl  output  1  packet valid, active-low.
REQ-014 bdvl  output  1  data valid, active-low.
REQ-015 bepvl  output  1  end-of-packet, active-high.
REQ-016 bdata  output  DW  backplane data.
REQ-017 abort_err, trunc_err  output  1 each  single-cycle error pulses.
REQ-018 pkt_cnt  output  16  count of completed packets.

Function
REQ-019 FSM states: IDLE, XFER, GAP.
REQ-020 IDLE: if any req bit is set, load the one-hot gnt for the round-robin winner, then move to XFER on the next edge.
REQ-021 Round-robin search starts at (last winner + 1) mod NREQ; after reset the last winner is NREQ-1, so requester 0 wins first.
REQ-022 XFER: a word is accepted in every cycle where src_dv[g] = 1 for the granted index g.
REQ-023 The req bit is ignored during XFER; gnt holds until the packet ends.
REQ-024 All bus outputs are registered: an input sampled at edge N appears on the bus from edge N+1.
REQ-025 Accepted word: bpvl=0, bdvl=0, bdata=src_data slice g, and bepvl = src_last[g].
REQ-026 No word in XFER: bpvl=0, bdvl=1, bepvl=0, bdata holds its previous value.
REQ-027 bepvl=1 is only ever driven together with bdvl=0, never with bdvl=1.
REQ-028 Word counter: reset to 0 on grant, incremented per accepted word, 7 bits.
REQ-029 Truncation: if the accepted word is word MAX_WORDS and src_last=0, it is driven with bepvl=1, trunc_err pulses, and the packet ends.
REQ-030 Stall counter: cleared on each accepted word, incremented on each non-accepted XFER cycle.
REQ-031 Stall abort: when the stall counter reaches STALL_MAX, drive one word with bdata=0, bdvl=0, bepvl=1; abort_err pulses and the packet ends.
REQ-032 Packet end: gnt clears on the same edge that registers the end word; pkt_cnt increments by 1 (wrapping at 16'hFFFF -> 0); state moves to GAP.
REQ-033 Aborted and truncated packets are counted in pkt_cnt.
REQ-034 GAP: bpvl=1, bdvl=1, bepvl=0 for exactly IDLE_GAP cycles, then IDLE; requests are not granted during GAP.
REQ-035 src_dv from non-granted requesters, and words after src_last, are ignored.
REQ-036 If src_last and the truncation condition coincide, the packet ends normally; trunc_err does not pulse.

Reset
REQ-037 Assertion of rst_n=0 forces, asynchronously: state=IDLE, gnt=0, bpvl=1, bdvl=1, bepvl=0, bdata=0, abort_err=0, trunc_err=0, pkt_cnt=0, both counters=0, last winner=NREQ-1.
REQ-038 Reset during XFER drops the packet with no bepvl and no count; deassertion takes effect on the next clk edge.

Structure
REQ-039 Shared package bp_pkg holds the state enum, the default parameter constants, and the bus polarity constants (BPVL_ON=0, BDVL_ON=0).
REQ-040 A single sub-module, bp_rr_arb (round-robin one-hot picker, combinational plus last-winner register), is instantiated once.

Verification
REQ-041 req=4'b0101 held, each packet 3 words -> grants alternate 0,2,0,2; each packet shows 3 bdvl=0 cycles with bepvl on the third; 2 idle cycles between packets.
REQ-042 Requester 1 sends 100 words with no last -> the bus carries 64 words, bepvl on word 64, trunc_err pulses once, pkt_cnt+1.
REQ-043 Granted requester sends 2 words, then src_dv=0 for 16 cycles -> a zero word with bdvl=0, bepvl=1; abort_err pulses once; gnt clears.
REQ-044 rst_n pulsed low mid-packet (word 5) -> outputs go to reset values immediately; after release, requester 0 is granted first and pkt_cnt=0.
REQ-045 pkt_cnt preloaded near wrap (65535 packets, or by force) and one more packet sent -> pkt_cnt=0.
REQ-046 Continuous bus monitor across all tests -> bepvl never observed with bdvl=1 while bpvl=0, and gnt is always one-hot or zero.
